// File: rtl/lsram_fifo_ctrl_pkg.sv
// Shared widths and types for the LSRAM-backed FIFO controller.
package lsram_fifo_pkg;
  localparam int DWIDTH = 64;
  localparam int AWIDTH = 6;
  localparam int DEPTH  = 2**AWIDTH;

  typedef logic [AWIDTH-1:0] ptr_t;
  typedef logic [AWIDTH+1:0] cnt_t;
  typedef logic [DWIDTH-1:0] word_t;
endpackage

// File: rtl/lsram_fifo_ctrl_if.sv
// Producer, consumer and RAM-macro signals of the FIFO controller.
interface lsram_fifo_ctrl_if;
  import lsram_fifo_pkg::*;

  logic  we;
  word_t data;
  logic  full;
  logic  afull;
  logic  overflow;
  logic  re;
  word_t q;
  logic  dout_valid;
  logic  aempty;
  logic  underflow;
  cnt_t  wrcnt;
  ptr_t  ram_w_addr;
  word_t ram_w_data;
  logic  ram_w_en;
  ptr_t  ram_r_addr;
  logic  ram_r_en;
  word_t ram_r_data;

  modport master (
    output we, data, re, ram_r_data,
    input  full, afull, overflow, q, dout_valid, aempty, underflow, wrcnt,
           ram_w_addr, ram_w_data, ram_w_en, ram_r_addr, ram_r_en
  );

  modport slave (
    input  we, data, re, ram_r_data,
    output full, afull, overflow, q, dout_valid, aempty, underflow, wrcnt,
           ram_w_addr, ram_w_data, ram_w_en, ram_r_addr, ram_r_en
  );
endinterface

// File: rtl/lsram_fifo_ctrl_fwft_out_buf.sv
// Two-entry skid buffer holding RAM read data; slot0 is always the head word.
module fwft_out_buf
  import lsram_fifo_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       push,
  input  word_t      din,
  input  logic       pop,
  output word_t      head,
  output logic [1:0] count
);
  word_t slot0;
  word_t slot1;

  // Popping the last word leaves slot0 untouched so the head keeps its value while empty.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count <= 2'd0;
      slot0 <= '0;
      slot1 <= '0;
    end else begin
      count <= count + 2'(push) - 2'(pop);
      if (pop) begin
        if (count == 2'd2) begin
          slot0 <= slot1;
          if (push) slot1 <= din;
        end else if (push) begin
          slot0 <= din;
        end
      end else if (push) begin
        if (count == 2'd0) slot0 <= din;
        else               slot1 <= din;
      end
    end
  end

  assign head = slot0;
endmodule

// File: rtl/lsram_fifo_ctrl.sv
// FIFO controller for the 64x64 LSRAM macro with a first-word-fall-through output.
module lsram_fifo_ctrl
  import lsram_fifo_pkg::*;
#(
  parameter int AFULL_VAL  = 56,
  parameter int AEMPTY_VAL = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  lsram_fifo_ctrl_if.slave bus
);
  ptr_t       wptr;
  ptr_t       rptr;
  cnt_t       ram_cnt;
  cnt_t       ram_cnt_n;
  cnt_t       wrcnt;
  cnt_t       wrcnt_n;
  logic       inflight;
  logic [1:0] buf_cnt;
  logic [1:0] buf_cnt_n;
  logic [2:0] buf_load;
  logic       full;
  logic       wr_acc;
  logic       rd_iss;
  logic       pop;
  logic       afull;
  logic       aempty;
  logic       overflow;
  logic       underflow;
  word_t      head;

  assign full   = (ram_cnt == cnt_t'(DEPTH));
  assign pop    = bus.re & (buf_cnt != 2'd0);
  assign wr_acc = reset_n & bus.we & ~full;

  // Buffer slots committed after this cycle; a read is issued only if one will stay free.
  assign buf_load  = 3'(buf_cnt) + 3'(inflight) - 3'(pop);
  assign buf_cnt_n = buf_load[1:0];
  assign rd_iss    = reset_n & (ram_cnt != '0) & (buf_load < 3'd2);

  always_comb begin
    ram_cnt_n = ram_cnt;
    if (wr_acc && !rd_iss)      ram_cnt_n = ram_cnt + cnt_t'(1);
    else if (!wr_acc && rd_iss) ram_cnt_n = ram_cnt - cnt_t'(1);
  end

  assign wrcnt_n = ram_cnt_n + cnt_t'(rd_iss) + cnt_t'(buf_cnt_n);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wptr      <= '0;
      rptr      <= '0;
      ram_cnt   <= '0;
      inflight  <= 1'b0;
      wrcnt     <= '0;
      afull     <= 1'b0;
      aempty    <= 1'b1;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wptr <= wptr + ptr_t'(1);
      if (rd_iss) rptr <= rptr + ptr_t'(1);
      ram_cnt   <= ram_cnt_n;
      inflight  <= rd_iss;
      wrcnt     <= wrcnt_n;
      afull     <= (wrcnt_n >= cnt_t'(AFULL_VAL));
      aempty    <= (wrcnt_n <= cnt_t'(AEMPTY_VAL));
      overflow  <= bus.we & full;
      underflow <= bus.re & (buf_cnt == 2'd0);
    end
  end

  fwft_out_buf u_out_buf (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (inflight),
    .din     (bus.ram_r_data),
    .pop     (pop),
    .head    (head),
    .count   (buf_cnt)
  );

  assign bus.full       = full;
  assign bus.afull      = afull;
  assign bus.overflow   = overflow;
  assign bus.q          = head;
  assign bus.dout_valid = (buf_cnt != 2'd0);
  assign bus.aempty     = aempty;
  assign bus.underflow  = underflow;
  assign bus.wrcnt      = wrcnt;
  assign bus.ram_w_addr = wptr;
  assign bus.ram_w_data = bus.data;
  assign bus.ram_w_en   = wr_acc;
  assign bus.ram_r_addr = rptr;
  assign bus.ram_r_en   = rd_iss;
endmodule
